// File: rtl/ad9516_spi_target.sv
// AD9516-style SPI target: 16-bit instruction, then byte writes/reads against a local 8-bit register file.
// Latency: write commit pulses one cycle after the 8th SCLK rise is detected (~3 sys_clk after the pin edge).
// Backpressure: none, the master owns the pace; SCLK must be at most sys_clk/8.
//
// Ports:
//   sys_clk_i, rst_i       system clock, synchronous active-high reset
//   CS_I, SCLK_I, MOSI_I   asynchronous SPI pins, oversampled through 2-FF synchronizers
//   MISO_O, miso_oe_o      read data (MSB first) and its output enable
//   wr_valid_o/addr/data   one-cycle pulse per committed register write
//   io_update_o            pulse on write of UPD_ADDR with data bit0 set
//   frame_err_o            pulse when a frame ends malformed
module ad9516_spi_target #(
    parameter int          REG_ADDR_W = 10,
    parameter logic [12:0] UPD_ADDR   = 13'h232
) (
    input  logic        sys_clk_i,
    input  logic        rst_i,
    input  logic        CS_I,
    input  logic        SCLK_I,
    input  logic        MOSI_I,
    output logic        MISO_O,
    output logic        miso_oe_o,
    output logic        wr_valid_o,
    output logic [12:0] wr_addr_o,
    output logic [7:0]  wr_data_o,
    output logic        io_update_o,
    output logic        frame_err_o
);
    localparam int DEPTH = 1 << REG_ADDR_W;

    typedef enum logic [2:0] {IDLE, INSTR, WR_DATA, RD_DATA, WAIT_CS} state_t;

    // synchronizers; CS flops reset low so a CS already held low at reset
    // release is not mistaken for a falling edge
    logic cs_meta_q, cs_sync_q, cs_prev_q;
    logic sclk_meta_q, sclk_sync_q, sclk_prev_q;
    logic mosi_meta_q, mosi_sync_q;

    state_t            state_q, state_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [1:0]        w_q, w_d;
    logic [12:0]       addr_q, addr_d;
    logic [14:0]       sh_q, sh_d;
    logic [7:0]        tx_q, tx_d;
    logic              armed_q, armed_d;
    logic              miso_q, miso_d;
    logic              oe_q, oe_d;
    logic              wr_valid_q, wr_valid_d;
    logic [12:0]       wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              io_update_q, io_update_d;
    logic              frame_err_q, frame_err_d;

    logic [7:0]            mem_q [DEPTH];
    logic                  mem_we;
    logic [REG_ADDR_W-1:0] mem_waddr;

    logic        cs_fall, sclk_rise, sclk_fall;
    logic [15:0] instr;
    logic [7:0]  rx_byte;

    function automatic logic in_range(input logic [12:0] a);
        return 32'(a) < 32'(DEPTH);
    endfunction

    function automatic logic [7:0] rd_byte(input logic [12:0] a);
        return in_range(a) ? mem_q[a[REG_ADDR_W-1:0]] : 8'h00;
    endfunction

    assign cs_fall   = !cs_sync_q && cs_prev_q;
    // a rise only counts once SCLK has been seen low inside the frame
    assign sclk_rise = sclk_sync_q && !sclk_prev_q && armed_q;
    assign sclk_fall = !sclk_sync_q && sclk_prev_q;
    assign instr     = {sh_q, mosi_sync_q};
    assign rx_byte   = {sh_q[6:0], mosi_sync_q};

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        w_d         = w_q;
        addr_d      = addr_q;
        sh_d        = sh_q;
        tx_d        = tx_q;
        armed_d     = armed_q || !sclk_sync_q;
        miso_d      = miso_q;
        oe_d        = oe_q;
        wr_valid_d  = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        io_update_d = 1'b0;
        frame_err_d = 1'b0;
        mem_we      = 1'b0;
        mem_waddr   = addr_q[REG_ADDR_W-1:0];

        if (sclk_rise) begin
            sh_d = {sh_q[13:0], mosi_sync_q};
        end

        case (state_q)
            IDLE: begin
                bit_cnt_d  = 4'd0;
                byte_cnt_d = 2'd0;
                oe_d       = 1'b0;
                miso_d     = 1'b0;
                armed_d    = 1'b0;
                if (cs_fall) begin
                    state_d = INSTR;
                    armed_d = !sclk_sync_q;
                end
            end

            INSTR: begin
                if (cs_sync_q) begin
                    state_d     = IDLE;
                    frame_err_d = 1'b1;
                end else if (sclk_rise) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd15) begin
                        w_d        = instr[14:13];
                        addr_d     = instr[12:0];
                        bit_cnt_d  = 4'd0;
                        byte_cnt_d = 2'd0;
                        if (instr[15]) begin
                            state_d = RD_DATA;
                            tx_d    = rd_byte(instr[12:0]);
                        end else begin
                            state_d = WR_DATA;
                        end
                    end
                end
            end

            WR_DATA, RD_DATA: begin
                if (cs_sync_q) begin
                    state_d     = IDLE;
                    oe_d        = 1'b0;
                    miso_d      = 1'b0;
                    // streaming frames may end on any byte boundary
                    frame_err_d = (bit_cnt_q[2:0] != 3'd0) || (w_q != 2'b11);
                end else begin
                    if (state_q == RD_DATA && sclk_fall) begin
                        oe_d   = 1'b1;
                        miso_d = tx_q[7];
                        tx_d   = {tx_q[6:0], 1'b0};
                    end
                    if (sclk_rise) begin
                        bit_cnt_d = {1'b0, bit_cnt_q[2:0] + 3'd1};
                        if (bit_cnt_q[2:0] == 3'd7) begin
                            addr_d     = addr_q - 13'd1;
                            byte_cnt_d = byte_cnt_q + 2'd1;
                            if (state_q == WR_DATA) begin
                                wr_valid_d  = 1'b1;
                                wr_addr_d   = addr_q;
                                wr_data_d   = rx_byte;
                                mem_we      = in_range(addr_q);
                                io_update_d = (addr_q == UPD_ADDR) && rx_byte[0];
                            end else begin
                                tx_d = rd_byte(addr_q - 13'd1);
                            end
                            // w_q encodes byte count minus one for fixed lengths
                            if (w_q != 2'b11 && byte_cnt_q == w_q) begin
                                state_d = WAIT_CS;
                                oe_d    = 1'b0;
                                miso_d  = 1'b0;
                            end
                        end
                    end
                end
            end

            WAIT_CS: begin
                oe_d   = 1'b0;
                miso_d = 1'b0;
                if (cs_sync_q) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
            cs_meta_q   <= 1'b0;
            cs_sync_q   <= 1'b0;
            cs_prev_q   <= 1'b0;
            sclk_meta_q <= 1'b0;
            sclk_sync_q <= 1'b0;
            sclk_prev_q <= 1'b0;
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
            state_q     <= IDLE;
            bit_cnt_q   <= 4'd0;
            byte_cnt_q  <= 2'd0;
            w_q         <= 2'd0;
            addr_q      <= 13'd0;
            sh_q        <= 15'd0;
            tx_q        <= 8'd0;
            armed_q     <= 1'b0;
            miso_q      <= 1'b0;
            oe_q        <= 1'b0;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= 13'd0;
            wr_data_q   <= 8'd0;
            io_update_q <= 1'b0;
            frame_err_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            cs_meta_q   <= CS_I;
            cs_sync_q   <= cs_meta_q;
            cs_prev_q   <= cs_sync_q;
            sclk_meta_q <= SCLK_I;
            sclk_sync_q <= sclk_meta_q;
            sclk_prev_q <= sclk_sync_q;
            mosi_meta_q <= MOSI_I;
            mosi_sync_q <= mosi_meta_q;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            w_q         <= w_d;
            addr_q      <= addr_d;
            sh_q        <= sh_d;
            tx_q        <= tx_d;
            armed_q     <= armed_d;
            miso_q      <= miso_d;
            oe_q        <= oe_d;
            wr_valid_q  <= wr_valid_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            io_update_q <= io_update_d;
            frame_err_q <= frame_err_d;
            if (mem_we) begin
                mem_q[mem_waddr] <= rx_byte;
            end
        end
    end

    assign MISO_O      = miso_q;
    assign miso_oe_o   = oe_q;
    assign wr_valid_o  = wr_valid_q;
    assign wr_addr_o   = wr_addr_q;
    assign wr_data_o   = wr_data_q;
    assign io_update_o = io_update_q;
    assign frame_err_o = frame_err_q;

endmodule

// File: tb/tb_ad9516_spi_target.sv
// Bench for ad9516_spi_target: drives SPI frames as the master, scoreboards writes and read bytes.
// Latency: writes are matched whenever wr_valid_o appears; read bytes are matched at each 8th SCLK rise.
// Backpressure: none; the bench paces SCLK at 16 sys_clk per bit.
module tb_ad9516_spi_target;
    localparam int HALF = 8;

    logic        clk;
    logic        rst_i;
    logic        CS_I, SCLK_I, MOSI_I;
    logic        MISO_O, miso_oe_o, wr_valid_o, io_update_o, frame_err_o;
    logic [12:0] wr_addr_o;
    logic [7:0]  wr_data_o;

    int n_cmp = 0;
    int n_bad = 0;
    int err_seen = 0;
    int err_exp = 0;

    logic [21:0] exp_wr [$];   // {io_update, addr, data}
    logic [8:0]  exp_rd [$];   // {miso_oe at 8th rise, byte}
    logic [7:0]  wbuf [4];

    ad9516_spi_target dut (
        .sys_clk_i   (clk),
        .rst_i       (rst_i),
        .CS_I        (CS_I),
        .SCLK_I      (SCLK_I),
        .MOSI_I      (MOSI_I),
        .MISO_O      (MISO_O),
        .miso_oe_o   (miso_oe_o),
        .wr_valid_o  (wr_valid_o),
        .wr_addr_o   (wr_addr_o),
        .wr_data_o   (wr_data_o),
        .io_update_o (io_update_o),
        .frame_err_o (frame_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // output monitor: every write pulse must match the head of the write scoreboard
    always @(negedge clk) begin
        if (!rst_i) begin
            if (wr_valid_o) begin
                if (exp_wr.size() == 0) begin
                    chk("wr_unexpected", 32'(wr_valid_o), 32'd0);
                end else begin
                    chk("wr_event", 32'({io_update_o, wr_addr_o, wr_data_o}), 32'(exp_wr.pop_front()));
                end
            end else if (io_update_o) begin
                chk("io_without_wr", 32'(io_update_o), 32'd0);
            end
            if (frame_err_o) err_seen++;
            if (MISO_O && !miso_oe_o) chk("miso_without_oe", 32'(MISO_O), 32'(miso_oe_o));
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bit(input logic b, output logic r, output logic oe);
        MOSI_I = b;
        wait_cyc(HALF);
        SCLK_I = 1'b1;
        r  = MISO_O;
        oe = miso_oe_o;
        wait_cyc(HALF);
        SCLK_I = 1'b0;
    endtask

    task automatic spi_frame(input logic [15:0] instr, input int ninstr, input int ndata,
                             input bit sclk_hi_start, input bit is_read);
        logic       r, oe;
        logic [7:0] rb;
        logic [8:0] e;
        rb = 8'h00;
        if (sclk_hi_start) SCLK_I = 1'b1;
        CS_I = 1'b0;
        wait_cyc(HALF);
        SCLK_I = 1'b0;
        for (int i = 0; i < ninstr; i++) spi_bit(instr[15-i], r, oe);
        for (int j = 0; j < ndata; j++) begin
            spi_bit(wbuf[j/8][7-(j%8)], r, oe);
            rb = {rb[6:0], r};
            if (is_read && (j % 8) == 7 && exp_rd.size() > 0) begin
                e = exp_rd.pop_front();
                chk("rd_byte", 32'(rb), 32'(e[7:0]));
                chk("rd_oe", 32'(oe), 32'(e[8]));
            end
        end
        wait_cyc(HALF);
        CS_I = 1'b1;
        wait_cyc(4 * HALF);
    endtask

    initial begin
        logic r, oe;
        CS_I = 1'b1; SCLK_I = 1'b0; MOSI_I = 1'b0; rst_i = 1'b1;
        wbuf[0] = 8'h00; wbuf[1] = 8'h00; wbuf[2] = 8'h00; wbuf[3] = 8'h00;
        wait_cyc(4);
        chk("reset_outputs", 32'({MISO_O, miso_oe_o, wr_valid_o, wr_addr_o, wr_data_o, io_update_o, frame_err_o}), 32'd0);
        rst_i = 1'b0;
        wait_cyc(8);

        // read of untouched register after reset
        exp_rd.push_back({1'b1, 8'h00});
        spi_frame(16'h8005, 16, 8, 1'b0, 1'b1);

        // single-byte write then read back
        wbuf[0] = 8'h7C;
        exp_wr.push_back({1'b0, 13'h010, 8'h7C});
        spi_frame(16'h0010, 16, 8, 1'b0, 1'b0);
        exp_rd.push_back({1'b1, 8'h7C});
        spi_frame(16'h8010, 16, 8, 1'b0, 1'b1);

        // three-byte write with descending address, then three-byte read
        wbuf[0] = 8'hA1; wbuf[1] = 8'hB2; wbuf[2] = 8'hC3;
        exp_wr.push_back({1'b0, 13'h0F2, 8'hA1});
        exp_wr.push_back({1'b0, 13'h0F1, 8'hB2});
        exp_wr.push_back({1'b0, 13'h0F0, 8'hC3});
        spi_frame(16'h40F2, 16, 24, 1'b0, 1'b0);
        exp_rd.push_back({1'b1, 8'hA1});
        exp_rd.push_back({1'b1, 8'hB2});
        exp_rd.push_back({1'b1, 8'hC3});
        spi_frame(16'hC0F2, 16, 24, 1'b0, 1'b1);

        // one-byte read followed by extra clocks: target idles with MISO low
        exp_rd.push_back({1'b1, 8'hB2});
        exp_rd.push_back({1'b0, 8'h00});
        spi_frame(16'h80F1, 16, 16, 1'b0, 1'b1);

        // two-byte write, streaming read across the 0x0000 wrap
        wbuf[0] = 8'h11; wbuf[1] = 8'h22;
        exp_wr.push_back({1'b0, 13'h001, 8'h11});
        exp_wr.push_back({1'b0, 13'h000, 8'h22});
        spi_frame(16'h2001, 16, 16, 1'b0, 1'b0);
        exp_rd.push_back({1'b1, 8'h11});
        exp_rd.push_back({1'b1, 8'h22});
        exp_rd.push_back({1'b1, 8'h00});
        spi_frame(16'hE001, 16, 24, 1'b0, 1'b1);

        // IO update register: pulse only when data bit0 is set; CS falls with SCLK high
        wbuf[0] = 8'h01;
        exp_wr.push_back({1'b1, 13'h232, 8'h01});
        spi_frame(16'h0232, 16, 8, 1'b1, 1'b0);
        wbuf[0] = 8'h00;
        exp_wr.push_back({1'b0, 13'h232, 8'h00});
        spi_frame(16'h0232, 16, 8, 1'b1, 1'b0);

        // extra clocks after a one-byte write are ignored
        wbuf[0] = 8'h33; wbuf[1] = 8'hFF;
        exp_wr.push_back({1'b0, 13'h060, 8'h33});
        spi_frame(16'h0060, 16, 16, 1'b0, 1'b0);
        chk("no_err_after_extra_clocks", 32'(err_seen), 32'(err_exp));

        // malformed frames: short instruction, then partial data byte
        spi_frame(16'h0050, 12, 0, 1'b0, 1'b0);
        err_exp++;
        chk("frame_err_short_instr", 32'(err_seen), 32'(err_exp));
        wbuf[0] = 8'hFF;
        spi_frame(16'h0050, 16, 4, 1'b0, 1'b0);
        err_exp++;
        chk("frame_err_partial_byte", 32'(err_seen), 32'(err_exp));

        // recovery: valid frame after errors
        wbuf[0] = 8'h5A;
        exp_wr.push_back({1'b0, 13'h050, 8'h5A});
        spi_frame(16'h0050, 16, 8, 1'b0, 1'b0);
        exp_rd.push_back({1'b1, 8'h5A});
        spi_frame(16'h8050, 16, 8, 1'b0, 1'b1);

        // reset mid-frame with CS held low: rest of that frame must be ignored
        CS_I = 1'b0;
        wait_cyc(HALF);
        for (int i = 0; i < 10; i++) spi_bit(1'b0, r, oe);
        rst_i = 1'b1;
        wait_cyc(4);
        chk("midframe_reset_outputs", 32'({MISO_O, miso_oe_o, wr_valid_o, io_update_o, frame_err_o}), 32'd0);
        rst_i = 1'b0;
        for (int i = 0; i < 14; i++) spi_bit(1'b0, r, oe);
        for (int i = 0; i < 8; i++) spi_bit(1'b1, r, oe);
        wait_cyc(HALF);
        CS_I = 1'b1;
        wait_cyc(4 * HALF);

        // register file cleared by reset
        exp_rd.push_back({1'b1, 8'h00});
        spi_frame(16'h8010, 16, 8, 1'b0, 1'b1);
        exp_rd.push_back({1'b1, 8'h00});
        spi_frame(16'h80F2, 16, 8, 1'b0, 1'b1);

        wait_cyc(20);
        chk("wr_pending", 32'(exp_wr.size()), 32'd0);
        chk("rd_pending", 32'(exp_rd.size()), 32'd0);
        chk("frame_err_total", 32'(err_seen), 32'(err_exp));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
